// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demux path: channel count, select width
// and the sequencer state encoding.
package demux_pkg;

  localparam int NUM_CHAN = 4;
  localparam int SEL_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

endpackage

// File: rtl/demux_rr_pick.sv
// Round-robin channel picker: lowest enabled channel, and the next enabled
// channel after the current one with wrap-around.
module demux_rr_pick
  import demux_pkg::*;
(
  input  logic [NUM_CHAN-1:0] mask,
  input  logic [SEL_W-1:0]    cur,
  output logic [SEL_W-1:0]    first,
  output logic [SEL_W-1:0]    next
);

  always_comb begin
    first = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (mask[i]) first = SEL_W'(i);
    end
  end

  // Scan from the farthest offset down so the nearest enabled channel wins;
  // with only cur enabled, next stays at cur.
  always_comb begin
    next = cur;
    for (int off = NUM_CHAN - 1; off >= 1; off--) begin
      if (mask[cur + SEL_W'(off)]) next = cur + SEL_W'(off);
    end
  end

endmodule

// File: rtl/demux_sel_sequencer.sv
// Feeds the 1-to-4 demux: accepts a handshaked bit stream and steps sel
// round-robin over the enabled channels every BITS_PER_CHAN bits.
module demux_sel_sequencer
  import demux_pkg::*;
#(
  parameter int BITS_PER_CHAN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [NUM_CHAN-1:0] chan_en,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                bit_ready,
  output logic                din,
  output logic [SEL_W-1:0]    sel,
  output logic                dout_valid,
  output logic                frame_start,
  output logic                busy,
  output logic                err_no_chan
);

  localparam int CNT_W = (BITS_PER_CHAN > 1) ? $clog2(BITS_PER_CHAN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_PER_CHAN - 1);

  state_t              state, state_nxt;
  logic [NUM_CHAN-1:0] en_q;
  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    cur_chan;
  logic [NUM_CHAN-1:0] pick_mask;
  logic [SEL_W-1:0]    pick_first, pick_next;
  logic                xfer, burst_end, start_ok;

  assign busy      = (state != IDLE);
  assign bit_ready = busy;
  assign xfer      = bit_valid && bit_ready;
  assign burst_end = xfer && (cnt == CNT_LAST);
  assign start_ok  = (state == IDLE) && start && (chan_en != '0);

  // One picker serves both phases: in IDLE it finds the first channel of the
  // live mask for start; once running it works on the captured mask.
  assign pick_mask = (state == IDLE) ? chan_en : en_q;

  demux_rr_pick u_pick (
    .mask  (pick_mask),
    .cur   (cur_chan),
    .first (pick_first),
    .next  (pick_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          if (burst_end || (cnt == '0 && !xfer)) state_nxt = IDLE;
          else                                   state_nxt = STOPPING;
        end
      end
      STOPPING: begin
        if (burst_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din         <= 1'b0;
      sel         <= '0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      err_no_chan <= 1'b0;
      en_q        <= '0;
      cnt         <= '0;
      cur_chan    <= '0;
    end else begin
      err_no_chan <= (state == IDLE) && start && (chan_en == '0);
      dout_valid  <= xfer;
      frame_start <= xfer && (cnt == '0) && (cur_chan == pick_first);
      if (xfer) begin
        din <= bit_in;
        sel <= cur_chan;
      end
      if (start_ok) begin
        en_q     <= chan_en;
        cur_chan <= pick_first;
        cnt      <= '0;
      end else if (xfer) begin
        if (cnt == CNT_LAST) begin
          cnt      <= '0;
          cur_chan <= pick_next;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
